// File: rtl/wb_stage_pipelined_if.sv
// ----------------------------------------------------------------------------
// wb_stage_pipelined_if
//   Instruction hand-off bundle from the memory stage into the writeback stage.
//   master : the memory stage (drives the instruction, observes in_ready)
//   slave  : the writeback stage (observes the instruction, drives in_ready)
//
//   in_valid          instruction presented
//   in_ready          stage can accept
//   in_pc             instruction PC
//   in_alu_result     ALU result, or effective address for loads
//   in_imm            immediate (lui)
//   in_rd             destination register
//   in_reg_write      instruction writes rd
//   in_wb_sel         00 ALU, 01 MEM, 10 PC+PC_STEP, 11 IMM
//   in_load_size      00 byte, 01 half, 10 word, 11 double
//   in_load_unsigned  1 = zero-extend, 0 = sign-extend
// ----------------------------------------------------------------------------
interface wb_stage_pipelined_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [XLEN-1:0]       in_pc;
    logic [XLEN-1:0]       in_alu_result;
    logic [XLEN-1:0]       in_imm;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_reg_write;
    logic [1:0]            in_wb_sel;
    logic [1:0]            in_load_size;
    logic                  in_load_unsigned;

    modport master (
        output in_valid, in_pc, in_alu_result, in_imm, in_rd,
               in_reg_write, in_wb_sel, in_load_size, in_load_unsigned,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_alu_result, in_imm, in_rd,
               in_reg_write, in_wb_sel, in_load_size, in_load_unsigned,
        output in_ready
    );
endinterface

// File: rtl/wb_stage_pipelined.sv
// ----------------------------------------------------------------------------
// wb_stage_pipelined
//   Registered writeback stage. Accepts one retiring instruction per cycle,
//   selects the writeback source (ALU / load data / link address / immediate),
//   waits for variable-latency load data with a timeout, extracts and extends
//   the addressed byte/half/word/double, and presents a one-cycle register-file
//   write. Counts committed instructions and flags memory timeouts (sticky).
//
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_bus            instruction hand-off (slave side)
//   mem_rvalid        load data valid
//   mem_rdata         aligned memory word
//   rf_we/waddr/wdata register-file write port
//   retired_count     committed-instruction count (wraps)
//   mem_timeout_err   sticky load-timeout flag
// ----------------------------------------------------------------------------
module wb_stage_pipelined #(
    parameter int XLEN        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int PC_STEP     = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wb_stage_pipelined_if.slave   in_bus,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [31:0]           retired_count,
    output logic                  mem_timeout_err
);
    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int TO_W  = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_MEM, S_COMMIT} state_t;
    typedef enum logic [1:0] {SEL_ALU, SEL_MEM, SEL_PC, SEL_IMM} wb_sel_t;

    state_t                state, state_next;
    wb_sel_t               sel;
    logic                  accept;
    logic [TO_W-1:0]       tcount, tcount_next;
    logic                  err_set;
    logic                  load_capture;
    logic                  commit_we;
    logic [REG_ADDR_W-1:0] commit_addr;
    logic [XLEN-1:0]       commit_data;
    logic [XLEN-1:0]       src_data;

    // Captured load context, held while waiting for memory.
    logic [OFF_W-1:0]      ld_off;
    logic [1:0]            ld_size;
    logic                  ld_unsigned;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic                  ld_reg_write;

    // Lane select, then left-justify and shift back down (arithmetic or
    // logical) so one expression handles every access width.
    function automatic logic [XLEN-1:0] extract(
        input logic [XLEN-1:0]  data,
        input logic [OFF_W-1:0] off,
        input logic [1:0]       size,
        input logic             uns
    );
        logic [OFF_W-1:0] lane;
        logic [XLEN-1:0]  sh;
        logic [XLEN-1:0]  r;
        int unsigned      amt;
        lane = off;
        amt  = XLEN - 32;
        case (size)
            2'b00: amt = XLEN - 8;
            2'b01: begin lane[0] = 1'b0;      amt = XLEN - 16; end
            2'b10: begin lane[1:0] = 2'b00;   amt = XLEN - 32; end
            default: begin lane = '0;         amt = 0;         end
        endcase
        sh = data >> {lane, 3'b000};
        r  = sh << amt;
        r  = uns ? (r >> amt) : XLEN'($signed(r) >>> amt);
        return r;
    endfunction

    assign sel             = wb_sel_t'(in_bus.in_wb_sel);
    assign in_bus.in_ready = (state != S_WAIT_MEM);
    assign accept          = in_bus.in_valid && in_bus.in_ready;

    always_comb begin
        case (sel)
            SEL_PC:  src_data = in_bus.in_pc + XLEN'(PC_STEP);
            SEL_IMM: src_data = in_bus.in_imm;
            default: src_data = in_bus.in_alu_result;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        tcount_next  = tcount;
        err_set      = 1'b0;
        load_capture = 1'b0;
        commit_we    = 1'b0;
        commit_addr  = in_bus.in_rd;
        commit_data  = src_data;
        case (state)
            S_WAIT_MEM: begin
                // Data arriving on the limit cycle takes priority over timeout.
                if (mem_rvalid) begin
                    state_next  = S_COMMIT;
                    commit_we   = ld_reg_write && (ld_rd != '0);
                    commit_addr = ld_rd;
                    commit_data = extract(mem_rdata, ld_off, ld_size, ld_unsigned);
                end else if (tcount == TO_W'(MEM_TIMEOUT - 1)) begin
                    state_next = S_COMMIT;
                    err_set    = 1'b1;
                end else begin
                    tcount_next = tcount + 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    if (sel == SEL_MEM) begin
                        state_next   = S_WAIT_MEM;
                        tcount_next  = '0;
                        load_capture = 1'b1;
                    end else begin
                        state_next = S_COMMIT;
                        commit_we  = in_bus.in_reg_write && (in_bus.in_rd != '0);
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we           <= 1'b0;
            rf_waddr        <= '0;
            rf_wdata        <= '0;
            retired_count   <= '0;
            mem_timeout_err <= 1'b0;
            tcount          <= '0;
        end else begin
            rf_we  <= commit_we;
            tcount <= tcount_next;
            // Address/data only move on a real write so they hold otherwise.
            if (commit_we) begin
                rf_waddr <= commit_addr;
                rf_wdata <= commit_data;
            end
            if (state == S_COMMIT) retired_count <= retired_count + 32'd1;
            if (err_set)           mem_timeout_err <= 1'b1;
        end
    end

    // NOTE: load context is pure datapath, only read in WAIT_MEM after being
    // written on acceptance, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_capture) begin
            ld_off       <= in_bus.in_alu_result[OFF_W-1:0];
            ld_size      <= in_bus.in_load_size;
            ld_unsigned  <= in_bus.in_load_unsigned;
            ld_rd        <= in_bus.in_rd;
            ld_reg_write <= in_bus.in_reg_write;
        end
    end
endmodule

// File: tb/tb_wb_stage_pipelined.sv
// ----------------------------------------------------------------------------
// tb_wb_stage_pipelined
//   Directed bench for wb_stage_pipelined (XLEN=32, MEM_TIMEOUT=4). Inputs are
//   driven and outputs sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_wb_stage_pipelined;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] retired_count;
    logic        mem_timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    wb_stage_pipelined_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

    wb_stage_pipelined #(
        .XLEN(32), .REG_ADDR_W(5), .PC_STEP(4), .MEM_TIMEOUT(4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_bus          (bus),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .retired_count   (retired_count),
        .mem_timeout_err (mem_timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] imm,
                         input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                         input logic [1:0] size, input logic uns);
        bus.in_valid         = 1'b1;
        bus.in_pc            = pc;
        bus.in_alu_result    = alu;
        bus.in_imm           = imm;
        bus.in_rd            = rd;
        bus.in_reg_write     = rw;
        bus.in_wb_sel        = sel;
        bus.in_load_size     = size;
        bus.in_load_unsigned = uns;
    endtask

    // Load whose data is sampled 'delay' edges after the accepting edge.
    // A stray mem_rvalid during the accept cycle must be ignored.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [4:0] rd, input int delay,
                           input logic [31:0] exp);
        issue(32'h0, addr, 32'h0, rd, 1'b1, 2'b01, size, uns);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        tick();
        bus.in_valid = 1'b0;
        mem_rvalid   = 1'b0;
        check({tag, "_ready_wait"}, bus.in_ready, 1'b0);
        for (int i = 0; i < delay - 1; i++) begin
            tick();
            check({tag, "_ready_wait"}, bus.in_ready, 1'b0);
            check({tag, "_we_wait"}, rf_we, 1'b0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80AA_BBCC;
        tick();
        mem_rvalid = 1'b0;
        check({tag, "_we"}, rf_we, 1'b1);
        check({tag, "_waddr"}, rf_waddr, rd);
        check({tag, "_wdata"}, rf_wdata, exp);
        tick();
        check({tag, "_we_off"}, rf_we, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        issue(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0);
        bus.in_valid = 1'b0;
        #12;
        check("rst_we", rf_we, 1'b0);
        check("rst_waddr", rf_waddr, 5'd0);
        check("rst_wdata", rf_wdata, 32'h0);
        check("rst_retired", retired_count, 32'd0);
        check("rst_err", mem_timeout_err, 1'b0);
        check("rst_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        // 1. ALU op, one-cycle latency, single-cycle write
        issue(32'h0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 2'b00, 2'b00, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        check("alu_we", rf_we, 1'b1);
        check("alu_waddr", rf_waddr, 5'd5);
        check("alu_wdata", rf_wdata, 32'h0000_1234);
        tick();
        check("alu_we_off", rf_we, 1'b0);
        check("alu_retired", retired_count, 32'd1);
        check("alu_hold", rf_wdata, 32'h0000_1234);

        // 2. jal wrap, then three back-to-back ALU ops
        issue(32'hFFFF_FFFC, 32'h0, 32'h0, 5'd1, 1'b1, 2'b10, 2'b00, 1'b0);
        tick();
        check("jal_we", rf_we, 1'b1);
        check("jal_waddr", rf_waddr, 5'd1);
        check("jal_wdata", rf_wdata, 32'h0);
        for (int i = 0; i < 3; i++) begin
            issue(32'h0, 32'h11 * (i + 1), 32'h0, 5'(i + 2), 1'b1, 2'b00, 2'b00, 1'b0);
            check("b2b_ready", bus.in_ready, 1'b1);
            tick();
            check("b2b_we", rf_we, 1'b1);
            check("b2b_waddr", rf_waddr, 5'(i + 2));
            check("b2b_wdata", rf_wdata, 32'h11 * (i + 1));
        end
        bus.in_valid = 1'b0;
        tick();
        check("b2b_we_off", rf_we, 1'b0);
        check("b2b_retired", retired_count, 32'd5);

        // 3. Loads: extraction, extension, latency 1..4 (4 = data on limit)
        do_load("lb",  32'h0000_1003, 2'b00, 1'b0, 5'd6,  3, 32'hFFFF_FF80);
        do_load("lbu", 32'h0000_1003, 2'b00, 1'b1, 5'd7,  4, 32'h0000_0080);
        check("limit_no_err", mem_timeout_err, 1'b0);
        do_load("lh",  32'h0000_1002, 2'b01, 1'b0, 5'd8,  1, 32'hFFFF_80AA);
        do_load("lhu", 32'h0000_1003, 2'b01, 1'b1, 5'd9,  1, 32'h0000_80AA);
        do_load("lw",  32'h0000_1001, 2'b10, 1'b0, 5'd10, 2, 32'h80AA_BBCC);
        check("ld_retired", retired_count, 32'd10);

        // 4. Timeout: 4 WAIT_MEM cycles, then COMMIT without write
        issue(32'h0, 32'h0000_2000, 32'h0, 5'd11, 1'b1, 2'b01, 2'b10, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_ready_wait", bus.in_ready, 1'b0);
            check("to_err_early", mem_timeout_err, 1'b0);
            tick();
        end
        check("to_ready", bus.in_ready, 1'b1);
        check("to_we", rf_we, 1'b0);
        check("to_err", mem_timeout_err, 1'b1);
        tick();
        check("to_retired", retired_count, 32'd11);
        check("to_err_sticky", mem_timeout_err, 1'b1);
        check("to_wdata_hold", rf_wdata, 32'h80AA_BBCC);
        check("to_waddr_hold", rf_waddr, 5'd10);

        // 5. x0 write and non-writing instruction are suppressed but retire
        issue(32'h0, 32'h0000_DEAD, 32'h0, 5'd0, 1'b1, 2'b00, 2'b00, 1'b0);
        tick();
        check("x0_we", rf_we, 1'b0);
        issue(32'h0, 32'h0, 32'h0000_5000, 5'd12, 1'b0, 2'b11, 2'b00, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        check("nowr_we", rf_we, 1'b0);
        check("x0_wdata_hold", rf_wdata, 32'h80AA_BBCC);
        tick();
        check("x0_retired", retired_count, 32'd13);

        // 6. Asynchronous reset in WAIT_MEM, late rvalid is dropped
        issue(32'h0, 32'h0000_3000, 32'h0, 5'd13, 1'b1, 2'b01, 2'b10, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        check("pre_rst_ready", bus.in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we", rf_we, 1'b0);
        check("arst_waddr", rf_waddr, 5'd0);
        check("arst_wdata", rf_wdata, 32'h0);
        check("arst_retired", retired_count, 32'd0);
        check("arst_err", mem_timeout_err, 1'b0);
        check("arst_ready", bus.in_ready, 1'b1);
        #1;
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        check("late_we", rf_we, 1'b0);
        check("late_ready", bus.in_ready, 1'b1);
        tick();
        check("late_we2", rf_we, 1'b0);
        check("late_retired", retired_count, 32'd0);
        check("late_wdata", rf_wdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end
endmodule
